// File: rtl/demux_stream_1ton.sv
// One-to-N stream demultiplexer.
// Each accepted word goes to one channel, or to every channel in broadcast mode.
// A single data register holds the word, and a per-channel valid mask tracks
// which channels still owe a downstream transfer. Slices whose valid bit is
// clear read zero. Out-of-range unicast selects are counted in a saturating
// drop counter.
module demux_stream_1ton #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 valid_in,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 bcast,
    output logic                 ready_out,
    output logic [N*WIDTH-1:0]   out,
    output logic [N-1:0]         valid_out,
    input  logic [N-1:0]         ready_in,
    output logic [7:0]           drop_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [SEL_W:0] N_L = (SEL_W+1)'(N);

    state_t             state_q, state_d;
    logic [N-1:0]       valid_q, valid_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [7:0]         drop_q, drop_d;

    logic [N-1:0]       load_mask;   // channels a word arriving now would target
    logic [N-1:0]       hold_mask;   // pending channels not transferring this cycle
    logic [N-1:0]       chan_done;   // channel is idle or transferring this cycle
    logic               accept;
    logic               in_range;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chan
            assign load_mask[gi] = bcast | (sel == SEL_W'(gi));
            assign chan_done[gi] = ~valid_q[gi] | ready_in[gi];
            assign hold_mask[gi] = valid_q[gi] & ~ready_in[gi];
            assign out[gi*WIDTH +: WIDTH] = valid_q[gi] ? data_q : '0;
        end
    endgenerate

    // A new word is accepted only once every pending channel has drained (or
    // drains in this very cycle), so loading it never overwrites undelivered data.
    // ready_out is also held low while reset is asserted.
    assign ready_out = rst_n & ((state_q == IDLE) | (&chan_done));
    assign accept    = valid_in & ready_out;
    assign in_range  = ({1'b0, sel} < N_L);

    assign valid_out = valid_q;
    assign drop_cnt  = drop_q;

    // Next-state: per-channel clear on transfer, full reload on acceptance, FSM tracking.
    always_comb begin
        state_d = state_q;
        valid_d = hold_mask;
        data_d  = data_q;
        drop_d  = drop_q;

        if (accept) begin
            // An out-of-range unicast gives an all-zero load mask, so the word
            // is consumed without raising any valid bit.
            valid_d = load_mask;
            data_d  = data_in;
            if (!bcast && !in_range && (drop_q != 8'hFF)) begin
                drop_d = drop_q + 8'd1;
            end
        end

        case (state_q)
            IDLE: if (|valid_d)  state_d = BUSY;
            BUSY: if (~|valid_d) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers, cleared asynchronously so a pending word is discarded on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= '0;
            data_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_demux_stream_1ton.sv
// Bench for demux_stream_1ton with N=5 and WIDTH=16. Five channels is not a
// power of two, so selects 5..7 exercise the drop path. Accepted words are
// pushed to per-channel expectation queues and popped on each channel transfer.
module tb_demux_stream_1ton;

    localparam int TN = 5;
    localparam int TW = 16;
    localparam int TS = 3;

    logic               clk;
    logic               rst_n;
    logic [TW-1:0]      data_in;
    logic               valid_in;
    logic [TS-1:0]      sel;
    logic               bcast;
    logic               ready_out;
    logic [TN*TW-1:0]   out_w;
    logic [TN-1:0]      valid_out;
    logic [TN-1:0]      ready_in;
    logic [7:0]         drop_cnt;

    int total = 0;
    int bad   = 0;

    logic [TW-1:0] expq [TN][$];
    int            drop_exp = 0;

    demux_stream_1ton #(.WIDTH(TW), .N(TN), .SEL_W(TS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .sel       (sel),
        .bcast     (bcast),
        .ready_out (ready_out),
        .out       (out_w),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: sample at the falling edge, retire transfers, record acceptance,
    // then advance to just after the next rising edge.
    task automatic cycle();
        logic [TW-1:0] e;
        @(negedge clk);
        chk("drop_cnt", 64'(drop_cnt), 64'(drop_exp));
        for (int k = 0; k < TN; k++) begin
            if (valid_out[k] && ready_in[k]) begin
                if (expq[k].size() == 0) begin
                    chk($sformatf("unexpected ch%0d", k), 64'(1), 64'(0));
                end else begin
                    e = expq[k].pop_front();
                    chk($sformatf("ch%0d data", k), 64'(out_w[k*TW +: TW]), 64'(e));
                end
            end
        end
        if (valid_in && ready_out) begin
            if (bcast) begin
                for (int k = 0; k < TN; k++) expq[k].push_back(data_in);
            end else if (int'(sel) < TN) begin
                expq[sel].push_back(data_in);
            end else if (drop_exp < 255) begin
                drop_exp++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        data_in  = '0;
        valid_in = 1'b0;
        sel      = '0;
        bcast    = 1'b0;
        ready_in = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst valid_out", 64'(valid_out), 64'(0));
        chk("rst out", 64'(out_w), 64'(0));
        chk("rst drop_cnt", 64'(drop_cnt), 64'(0));
        chk("rst ready_out", 64'(ready_out), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post-rst ready_out", 64'(ready_out), 64'(1));

        // Unicast sweep across every channel, downstream always ready.
        ready_in = '1;
        for (int i = 0; i < TN; i++) begin
            valid_in = 1'b1;
            data_in  = 16'h00A5;
            sel      = TS'(i);
            #1;
            chk("sweep ready_out", 64'(ready_out), 64'(1));
            cycle();
            chk("sweep valid_out", 64'(valid_out), 64'(1 << i));
        end
        valid_in = 1'b0;
        cycle();
        chk("sweep idle", 64'(valid_out), 64'(0));

        // Broadcast, then release channels one at a time.
        ready_in = '0;
        valid_in = 1'b1;
        bcast    = 1'b1;
        data_in  = 16'h003C;
        cycle();
        valid_in = 1'b0;
        bcast    = 1'b0;
        chk("bcast valid_out", 64'(valid_out), 64'(5'b11111));
        for (int k = 0; k < TN; k++) begin
            ready_in = TN'(1 << k);
            #1;
            chk("bcast ready_out", 64'(ready_out), 64'(k == TN-1));
            cycle();
            chk("bcast drain", 64'(valid_out), 64'((5'b11111 << (k+1)) & 5'b11111));
        end

        // Back-pressure on channel 2 with a second word waiting upstream.
        ready_in = '0;
        valid_in = 1'b1;
        sel      = 3'd2;
        data_in  = 16'h1111;
        cycle();
        data_in  = 16'h2222;
        sel      = 3'd1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp ready_out", 64'(ready_out), 64'(0));
            chk("bp valid_out", 64'(valid_out), 64'(5'b00100));
            chk("bp hold data", 64'(out_w[2*TW +: TW]), 64'(16'h1111));
            cycle();
        end
        ready_in = '1;
        #1;
        chk("bp release ready", 64'(ready_out), 64'(1));
        cycle();
        chk("bp no bubble", 64'(valid_out), 64'(5'b00010));
        valid_in = 1'b0;
        cycle();

        // Out-of-range selects: counted, never delivered, counter saturates.
        valid_in = 1'b1;
        for (int i = 0; i < 300; i++) begin
            sel     = TS'(5 + (i % 3));
            data_in = 16'(i);
            cycle();
            if (valid_out != '0) chk("drop valid_out", 64'(valid_out), 64'(0));
        end
        valid_in = 1'b0;
        cycle();
        chk("drop saturate", 64'(drop_cnt), 64'(255));

        // Asynchronous reset while a word is pending.
        ready_in = '0;
        valid_in = 1'b1;
        sel      = 3'd3;
        data_in  = 16'hBEEF;
        cycle();
        valid_in = 1'b0;
        chk("pre-rst busy", 64'(valid_out), 64'(5'b01000));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async valid_out", 64'(valid_out), 64'(0));
        chk("async out", 64'(out_w), 64'(0));
        chk("async drop_cnt", 64'(drop_cnt), 64'(0));
        chk("async ready_out", 64'(ready_out), 64'(0));
        for (int k = 0; k < TN; k++) expq[k].delete();
        drop_exp = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ready_in = '1;
        valid_in = 1'b1;
        sel      = 3'd0;
        data_in  = 16'h0077;
        cycle();
        chk("post-rst accept", 64'(valid_out), 64'(5'b00001));
        valid_in = 1'b0;
        cycle();

        // Random traffic.
        for (int c = 0; c < 10000; c++) begin
            valid_in = ($urandom_range(0, 9) < 7);
            bcast    = ($urandom_range(0, 7) == 0);
            sel      = TS'($urandom_range(0, 7));
            data_in  = 16'($urandom);
            ready_in = TN'($urandom);
            cycle();
        end
        valid_in = 1'b0;
        bcast    = 1'b0;
        ready_in = '1;
        repeat (4) cycle();
        for (int k = 0; k < TN; k++) begin
            chk($sformatf("ch%0d leftover", k), 64'(expq[k].size()), 64'(0));
        end
        chk("final idle", 64'(valid_out), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux_stream_1ton.md
DEMUX_STREAM_1TON -- requirements
Module: demux_stream_1ton

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (legal 1..64).
REQ-002 Parameter N, default 4, output channel count (legal 2..16).
REQ-003 Parameter SEL_W, default 2, select width; SHALL equal clog2(N).
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 data_in  input  WIDTH  upstream data word.
REQ-007 valid_in  input  1  upstream word valid.
REQ-008 sel  input  SEL_W  destination channel, sampled with data_in.
REQ-009 bcast  input  1  broadcast mode, sampled with data_in; 1 = deliver to all N channels, sel ignored.
REQ-010 ready_out  output  1  block can accept a word this cycle.
REQ-011 out  output  N*WIDTH  channel k data at bits [k*WIDTH +: WIDTH].
REQ-012 valid_out  output  N  per-channel valid.
REQ-013 ready_in  input  N  per-channel downstream ready.
REQ-014 drop_cnt  output  8  count of words dropped for out-of-range sel.

Function
REQ-015 Upstream transfer occurs in a cycle where valid_in=1 and ready_out=1; no other cycle accepts data.
REQ-016 Channel k transfer occurs in a cycle where valid_out[k]=1 and ready_in[k]=1.
REQ-017 States: IDLE (no pending bits) and BUSY (one or more valid_out bits set).
REQ-018 ready_out SHALL be 1 in IDLE, and in BUSY only when every set valid_out bit has its ready_in bit high that cycle (combinational from ready_in, registered state).
REQ-019 Latency: a word accepted at edge t SHALL appear on out/valid_out from edge t (registered), i.e. visible the cycle after acceptance.
REQ-020 Unicast (bcast=0, sel<N): only valid_out[sel] set; out slice sel = data_in.
REQ-021 Broadcast (bcast=1): all N valid_out bits set; every out slice = data_in.
REQ-022 Each valid_out bit clears individually on its own channel transfer; remaining bits and data hold unchanged.
REQ-023 BUSY -> IDLE when the last set bit clears with no new acceptance in the same cycle.
REQ-024 Simultaneous last-bit clear and new acceptance: new word loads that edge, state stays BUSY, no bubble cycle; sustained unicast throughput one word per cycle.
REQ-025 Out slices whose valid_out bit is 0 SHALL read all zeros.
REQ-026 Out-of-range (bcast=0, sel>=N, only possible when N is not a power of two): word accepted, no valid_out set, drop_cnt increments by 1.
REQ-027 drop_cnt SHALL saturate at 255, never wrap.
REQ-028 data_in, sel and bcast SHALL be ignored in any cycle without an upstream transfer.
REQ-029 ready_in bits of channels with valid_out=0 SHALL have no effect.

Reset
REQ-030 rst_n=0 SHALL immediately, without a clock edge, force state IDLE, valid_out=0, out=0, drop_cnt=0.
REQ-031 ready_out SHALL be 0 while rst_n=0 and 1 from the first cycle after deassertion.
REQ-032 Reset asserted mid-BUSY SHALL discard the pending word; no channel transfer of it after reset releases.
REQ-033 Reset deassertion SHALL be applied synchronously to clk by the bench/system; behaviour thereafter from IDLE.

Verification
REQ-034 N=4, WIDTH=8: send 0xA5 with sel=0,1,2,3 in turn, all ready_in=1 -> valid_out 0001,0010,0100,1000 on consecutive cycles, matching slice = 0xA5, others 0x00, ready_out constantly 1.
REQ-035 Broadcast 0x3C, ready_in=0000 then channels asserted one per cycle 0001,0010,0100,1000 -> valid_out 1111,1110,1100,1000,0000; ready_out=1 only in the cycle ready_in[3] rises.
REQ-036 Back-pressure: unicast sel=2 with ready_in[2]=0 for 5 cycles -> valid_out=0100 and data held 5 cycles, ready_out=0, second valid_in word not accepted until ready_in[2]=1.
REQ-037 N=3: sel=3, bcast=0 sent 300 times -> valid_out stays 000, drop_cnt reaches 255 and holds.
REQ-038 Reset asserted asynchronously between edges during BUSY -> valid_out, out, drop_cnt zero immediately; after release first valid_in accepted normally.
REQ-039 Random stimulus, N=5, WIDTH=16, random valid_in/ready_in/sel/bcast over 10000 cycles -> scoreboard shows every accepted in-range word delivered exactly once per target channel, in order, no duplication or loss.
